// File: rtl/qracc_tile_if.sv
// qracc_tile_if: weight port, activation and result handshakes of the QR accumulator tile.
// master = tile controller side, slave = qracc_tile.
interface qracc_tile_if #(
    parameter int numRows    = 128,
    parameter int numCols    = 8,
    parameter int numInBits  = 4,
    parameter int numAccBits = 16
);
    localparam int AW = $clog2(numRows);
    logic                            wr_en;
    logic [AW-1:0]                   wr_addr;
    logic [numCols-1:0]              wr_data;
    logic                            wr_err;
    logic                            rd_en;
    logic [AW-1:0]                   rd_addr;
    logic [numCols-1:0]              rd_data;
    logic                            rd_valid;
    logic                            act_valid;
    logic                            act_ready;
    logic [numRows*numInBits-1:0]    act_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [numCols*numAccBits-1:0]   out_data;
    logic                            busy;
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, act_valid, act_data, out_ready,
        input  wr_err, rd_data, rd_valid, act_ready, out_valid, out_data, busy
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, act_valid, act_data, out_ready,
        output wr_err, rd_data, rd_valid, act_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/qracc_tile.sv
// qracc_tile: 1-bit weight SRAM with a bit-serial MAC (one activation plane per cycle, ADC-quantised popcounts).
// Defining QRACC_SIGNED_ACT_EN makes activations two's complement with signed accumulator saturation.
module qracc_tile #(
    parameter int numRows    = 128,
    parameter int numCols    = 8,
    parameter int numAdcBits = 4,
    parameter int numInBits  = 4,
    parameter int numAccBits = 16,
    parameter int adcShift   = 3
) (
    input logic         CLK,
    input logic         NRST,
    qracc_tile_if.slave bus
);
    localparam int PCW = $clog2(numRows + 1);
    localparam int BW  = (numInBits > 1) ? $clog2(numInBits) : 1;
    localparam int SW  = numAccBits + numInBits;
    localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, HOLD = 2'd2;
`ifdef QRACC_SIGNED_ACT_EN
    localparam logic signed [SW-1:0] SMAX = (SW'(1) << (numAccBits - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SMIN = -(SW'(1) << (numAccBits - 1));
`endif

    logic [numCols-1:0]                   mem [numRows];
    logic [1:0]                           state_q, state_d;
    logic [BW-1:0]                        b_q, b_d;
    logic [numRows*numInBits-1:0]         act_q, act_d;
    logic [numCols-1:0][numAccBits-1:0]   acc_q, acc_d, acc_nx;
    logic [numCols-1:0]                   rd_data_q, rd_data_d;
    logic                                 rd_valid_q, rd_valid_d;
    logic                                 wr_err_q, wr_err_d;
    logic                                 idle, compute, last, take;

    function automatic logic [numAccBits-1:0] mac_col(
        input logic [numRows*numInBits-1:0] act,
        input logic [BW-1:0]                b,
        input logic [numAccBits-1:0]        acc,
        input logic [numCols-1:0]           m [numRows],
        input int                           j
    );
        logic [PCW-1:0]        pc, shv;
        logic [numAdcBits-1:0] adc;
        logic [SW-1:0]         term, sum;
        pc = '0;
        for (int i = 0; i < numRows; i++) pc = pc + PCW'(act[i*numInBits + int'(b)] & m[i][j]);
        shv  = pc >> adcShift;
        adc  = (32'(shv) > 32'((1 << numAdcBits) - 1)) ? '1 : numAdcBits'(shv);
        term = SW'(adc) << b;
`ifdef QRACC_SIGNED_ACT_EN
        // the MSB plane carries negative weight in two's complement
        sum = (32'(b) == numInBits - 1) ? SW'($signed(acc)) - term : SW'($signed(acc)) + term;
        return ($signed(sum) > SMAX) ? SMAX[numAccBits-1:0]
             : ($signed(sum) < SMIN) ? SMIN[numAccBits-1:0]
             : sum[numAccBits-1:0];
`else
        sum = SW'(acc) + term;
        return (sum > SW'({numAccBits{1'b1}})) ? '1 : sum[numAccBits-1:0];
`endif
    endfunction

    assign idle    = state_q == IDLE;
    assign compute = state_q == COMPUTE;
    assign last    = compute && (32'(b_q) == numInBits - 1);
    assign take    = idle && bus.act_valid;

    always_comb begin
        acc_nx = acc_q;
        for (int j = 0; j < numCols; j++) acc_nx[j] = mac_col(act_q, b_q, acc_q[j], mem, j);
    end

    always_comb begin
        state_d    = take ? COMPUTE : last ? HOLD : (state_q == HOLD && bus.out_ready) ? IDLE : state_q;
        b_d        = compute ? b_q + BW'(1) : '0;
        act_d      = take ? bus.act_data : act_q;
        acc_d      = take ? '0 : compute ? acc_nx : acc_q;
        rd_data_d  = bus.rd_en ? mem[bus.rd_addr] : rd_data_q;
        rd_valid_d = bus.rd_en;
        wr_err_d   = bus.wr_en && !idle;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            b_q        <= '0;
            act_q      <= '0;
            acc_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            act_q      <= act_d;
            acc_q      <= acc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // weight array has no reset; a write in the handshake cycle is visible to the first plane
    always_ff @(posedge CLK) begin
        if (bus.wr_en && idle) mem[bus.wr_addr] <= bus.wr_data;
    end

    assign bus.act_ready = idle;
    assign bus.busy      = !idle;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_data  = acc_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_qracc_tile.sv
// tb_qracc_tile: random and directed stimulus; results are scored against an integer model of the tile.
module tb_qracc_tile;
    localparam int NR = 128, NC = 8, NAD = 4, NIB = 4, NA = 16, SH = 3, AW = $clog2(NR);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qracc_tile_if #(.numRows(NR), .numCols(NC), .numInBits(NIB), .numAccBits(NA)) bus ();
    qracc_tile #(.numRows(NR), .numCols(NC), .numAdcBits(NAD), .numInBits(NIB),
                 .numAccBits(NA), .adcShift(SH)) dut (.CLK(clk), .NRST(rst_n), .bus(bus));

    logic [NC-1:0]      mw [NR];
    logic [NC*NA-1:0]   exp_q [$];
    logic [NC*NA-1:0]   mon_e;
    int total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NC*NA-1:0] model(input logic [NR*NIB-1:0] a);
        logic [NC*NA-1:0] r;
        longint acc;
        int pc, adc;
        r = '0;
        for (int j = 0; j < NC; j++) begin
            acc = 0;
            for (int b = 0; b < NIB; b++) begin
                pc = 0;
                for (int i = 0; i < NR; i++) pc += (a[i*NIB+b] && mw[i][j]) ? 1 : 0;
                adc = ((pc >> SH) > 2**NAD - 1) ? 2**NAD - 1 : (pc >> SH);
`ifdef QRACC_SIGNED_ACT_EN
                acc += (b == NIB - 1) ? -(adc * 2**b) : adc * 2**b;
                if (acc > 2**(NA-1) - 1) acc = 2**(NA-1) - 1;
                if (acc < -(2**(NA-1))) acc = -(2**(NA-1));
`else
                acc += adc * 2**b;
                if (acc > 2**NA - 1) acc = 2**NA - 1;
`endif
            end
            r[j*NA +: NA] = acc[NA-1:0];
        end
        return r;
    endfunction

    function automatic logic [NR*NIB-1:0] rand_act();
        logic [NR*NIB-1:0] a;
        for (int i = 0; i < NR; i++) a[i*NIB +: NIB] = NIB'($urandom_range(0, 2**NIB - 1));
        return a;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%0h", bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.out_data !== mon_e) begin
                    bad++;
                    $display("FAIL out_data got=%0h want=%0h", bus.out_data, mon_e);
                end
            end
        end
    end

    task automatic write_row(input int r, input logic [NC-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(r); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        mw[r] = d;
    endtask

    task automatic read_chk(input int r, input string nm);
        bus.rd_en = 1'b1; bus.rd_addr = AW'(r);
        tick();
        bus.rd_en = 1'b0;
        chk({nm, "_valid"}, bus.rd_valid, 1'b1);
        chk(nm, bus.rd_data, mw[r]);
    endtask

    task automatic send(input logic [NR*NIB-1:0] a, input bit push, output int hc);
        int n;
        n = 0;
        bus.act_data = a; bus.act_valid = 1'b1;
        while (!bus.act_ready && n < 100) begin tick(); n++; end
        if (!bus.act_ready) begin total++; bad++; $display("FAIL act_timeout got=0 want=1"); end
        if (push) exp_q.push_back(model(a));
        @(posedge clk);
        hc = cyc;
        #1;
        bus.act_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        if (!bus.out_valid) begin total++; bad++; $display("FAIL out_timeout got=0 want=1"); end
    endtask

    task automatic wait_done(input bit stall);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            if (stall) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        if (exp_q.size() != 0 || bus.busy) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [NR*NIB-1:0] a, a2;
        int h1, h2, n;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
        bus.act_valid = 0; bus.act_data = '0; bus.out_ready = 1;
        repeat (3) tick();
        chk("rst_act_ready", bus.act_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_wr_err", bus.wr_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // all-ones weights, activation 1: popcount 128 clips to ADC full scale
        for (int i = 0; i < NR; i++) write_row(i, 8'hFF);
        chk("idle_wr_err", bus.wr_err, 1'b0);
        for (int i = 0; i < NR; i++) a[i*NIB +: NIB] = 4'h1;
        send(a, 1, h1);
        wait_valid(n);
        chk("latency", n, NIB);
        chk("clip_all15", bus.out_data, {NC{16'd15}});
        wait_done(0);

        // eight rows feed column 0 only
        for (int i = 0; i < NR; i++) write_row(i, (i < 8) ? 8'h01 : 8'h00);
        a = rand_act();
        for (int i = 0; i < 8; i++) a[i*NIB +: NIB] = 4'hF;
        send(a, 1, h1);
        wait_valid(n);
        chk("col0_15", bus.out_data, 128'd15);
        wait_done(0);

        // write during COMPUTE is dropped and flagged
        send(rand_act(), 1, h1);
        bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 8'hAA;
        bus.rd_en = 1; bus.rd_addr = 3;
        tick();
        bus.wr_en = 0; bus.rd_en = 0;
        chk("busy_wr_err", bus.wr_err, 1'b1);
        chk("busy_rd_valid", bus.rd_valid, 1'b1);
        chk("busy_rd_old", bus.rd_data, 8'h01);
        tick();
        chk("wr_err_pulse", bus.wr_err, 1'b0);
        chk("rd_valid_drop", bus.rd_valid, 1'b0);
        wait_done(0);
        read_chk(3, "rd_unchanged");

        // same-cycle read and write in IDLE returns old data
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 8'h5A;
        bus.rd_en = 1; bus.rd_addr = 5;
        tick();
        bus.wr_en = 0; bus.rd_en = 0;
        chk("rw_same_old", bus.rd_data, mw[5]);
        mw[5] = 8'h5A;
        read_chk(5, "rw_same_new");

        // result held while consumer stalls, then back-to-back vectors
        bus.out_ready = 0;
        a = rand_act();
        send(a, 1, h1);
        wait_valid(n);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_data", bus.out_data, model(a));
            chk("hold_act_ready", bus.act_ready, 1'b0);
        end
        bus.out_ready = 1;
        tick();
        chk("release_act_ready", bus.act_ready, 1'b1);
        chk("release_out_valid", bus.out_valid, 1'b0);
        send(rand_act(), 1, h1);
        send(rand_act(), 1, h2);
        chk("throughput", h2 - h1, NIB + 2);
        wait_done(0);

        // write landing in the handshake cycle pushes popcount from 7 to 8
        for (int i = 0; i < NR; i++) write_row(i, (i < 7) ? 8'hFF : 8'h00);
        for (int i = 0; i < NR; i++) a[i*NIB +: NIB] = 4'hF;
        bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 8'hFF;
        mw[7] = 8'hFF;
        send(a, 1, h1);
        bus.wr_en = 0;
        wait_valid(n);
        chk("wr_with_act", bus.out_data, {NC{16'd15}});
        wait_done(0);

        // reset in the middle of COMPUTE abandons the vector
        send(rand_act(), 0, h1);
        tick();
        rst_n = 0;
        tick();
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_act_ready", bus.act_ready, 1'b1);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out_data", bus.out_data, '0);
        rst_n = 1;
        tick();

        // random weights of varying density, random activations, random consumer stalls
        for (int it = 0; it < 24; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NR; i++) begin
                logic [NC-1:0] w1, w2;
                if (it % 4 == 0 || $urandom_range(0, 15) == 0) begin
                    w1 = NC'($urandom); w2 = NC'($urandom);
                    write_row(i, (mode == 0) ? w1 : (mode == 1) ? (w1 | w2) : (w1 & w2));
                end
            end
            a2 = rand_act();
            send(a2, 1, h1);
            wait_done(1);
            read_chk($urandom_range(0, NR - 1), "rand_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
